// File: rtl/fp_pkg.sv
// Shared definitions for the sequential floating-point multiplier: rounding
// mode encoding, FSM states and format-derived helper functions.
package fp_pkg;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100
  } rmode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_NORM = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Booth digits needed so that the zero-extended multiplier gives an exact unsigned product
  function automatic int fp_ndig(input int frc_w);
    return (frc_w + 3) / 2;
  endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth recoder: one overlapping multiplier triplet to a signed digit
// in {-2,-1,0,+1,+2}, expressed as zero / double / negate controls.
module booth_r4_enc (
  input  logic [2:0] trip,
  output logic       zero,
  output logic       x2,
  output logic       neg
);

  always_comb begin
    zero = (trip == 3'b000) || (trip == 3'b111);
    x2   = (trip == 3'b011) || (trip == 3'b100);
    neg  = trip[2] && !zero;
  end

endmodule

// File: rtl/fp_mul_seq.sv
// Sequential IEEE-style multiplier: radix-4 Booth significand product, one
// digit per cycle, then a single normalize/round cycle. Subnormals flush to zero.
module fp_mul_seq
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int FRC_W = 23
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1+EXP_W+FRC_W-1:0]   fp_X,
  input  logic [1+EXP_W+FRC_W-1:0]   fp_Y,
  input  logic [2:0]                 r_mode,
  output logic [1+EXP_W+FRC_W-1:0]   fp_Z,
  output logic                       ovrf,
  output logic                       udrf,
  output logic                       out_valid,
  input  logic                       out_ready
);

  localparam int W     = 1 + EXP_W + FRC_W;
  localparam int MW    = FRC_W + 1;
  localparam int PW    = 2 * MW;
  localparam int ACC_W = PW + 2;
  localparam int NDIG  = fp_ndig(FRC_W);
  localparam int MPL_W = 2 * NDIG + 1;
  localparam int EW    = EXP_W + 2;
  localparam int CNT_W = $clog2(NDIG + 1);

  localparam logic [CNT_W-1:0]      LAST_DIG = CNT_W'(NDIG - 1);
  localparam logic signed [EW-1:0]  BIAS     = EW'(fp_bias(EXP_W));
  localparam logic signed [EW-1:0]  EMAX     = EW'((1 << EXP_W) - 1);
  localparam logic [EXP_W-1:0]      EXP_ONES = '1;
  localparam logic [W-1:0]          QNAN     = {1'b0, EXP_ONES, 1'b1, {(FRC_W-1){1'b0}}};

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [W-1:0]              z_q, z_d;
  logic                      ovrf_q, ovrf_d;
  logic                      udrf_q, udrf_d;

  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [ACC_W-1:0]   mcand_q, mcand_d;
  logic [MPL_W-1:0]          mplr_q, mplr_d;
  logic signed [EW-1:0]      exp_q, exp_d;
  logic                      sign_q, sign_d;
  logic [2:0]                rmode_q, rmode_d;

  logic                      sx, sy, s_xy;
  logic [EXP_W-1:0]          ex, ey;
  logic [FRC_W-1:0]          fx, fy;
  logic                      x_nan, y_nan, x_inf, y_inf, x_zero, y_zero, is_special;
  logic [W-1:0]              special_z;

  logic                      dig_zero, dig_x2, dig_neg;
  logic signed [ACC_W-1:0]   pp_mag, pp;

  logic [PW-1:0]             prod, norm;
  logic                      hi, g_bit, r_bit, s_bit, inexact, inc;
  logic [MW-1:0]             mant;
  logic [MW:0]               mant_r;
  logic [FRC_W-1:0]          frac_r;
  logic signed [EW-1:0]      exp_r;
  logic                      ovf, udf;
  logic [W-1:0]              inf_z, maxf_z, ovf_z, norm_z;
  logic [1:0]                acc_hi_unused;

  // Operand classification
  always_comb begin
    sx     = fp_X[W-1];
    sy     = fp_Y[W-1];
    ex     = fp_X[W-2 -: EXP_W];
    ey     = fp_Y[W-2 -: EXP_W];
    fx     = fp_X[FRC_W-1:0];
    fy     = fp_Y[FRC_W-1:0];
    s_xy   = sx ^ sy;
    x_nan  = (ex == EXP_ONES) && (fx != '0);
    y_nan  = (ey == EXP_ONES) && (fy != '0);
    x_inf  = (ex == EXP_ONES) && (fx == '0);
    y_inf  = (ey == EXP_ONES) && (fy == '0);
    x_zero = (ex == '0);
    y_zero = (ey == '0);
    is_special = x_nan || y_nan || x_inf || y_inf || x_zero || y_zero;
    if (x_nan || y_nan || (x_inf && y_zero) || (y_inf && x_zero))
      special_z = QNAN;
    else if (x_inf || y_inf)
      special_z = {s_xy, EXP_ONES, {FRC_W{1'b0}}};
    else
      special_z = {s_xy, {(W-1){1'b0}}};
  end

  booth_r4_enc u_enc (
    .trip (mplr_q[2:0]),
    .zero (dig_zero),
    .x2   (dig_x2),
    .neg  (dig_neg)
  );

  // Partial product: multiplicand is pre-shifted two places per digit
  always_comb begin
    pp_mag = dig_x2 ? (mcand_q <<< 1) : mcand_q;
    pp     = dig_zero ? '0 : (dig_neg ? -pp_mag : pp_mag);
  end

  // Normalize and round the finished product
  always_comb begin
    prod          = acc_q[PW-1:0];
    acc_hi_unused = acc_q[ACC_W-1:PW];
    hi      = prod[PW-1];
    norm    = hi ? prod : {prod[PW-2:0], 1'b0};
    mant    = norm[PW-1 -: MW];
    g_bit   = norm[MW-1];
    r_bit   = norm[MW-2];
    s_bit   = |norm[MW-3:0];
    inexact = g_bit || r_bit || s_bit;
    case (rmode_q)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sign_q && inexact;
      RM_RUP:  inc = !sign_q && inexact;
      RM_RMM:  inc = g_bit;
      default: inc = g_bit && (r_bit || s_bit || mant[0]);
    endcase
    mant_r = {1'b0, mant} + {{MW{1'b0}}, inc};
    frac_r = mant_r[MW] ? mant_r[MW-1:1] : mant_r[FRC_W-1:0];
    exp_r  = exp_q + $signed({{(EW-1){1'b0}}, hi}) + $signed({{(EW-1){1'b0}}, mant_r[MW]});
    ovf    = (exp_r >= EMAX);
    udf    = exp_r[EW-1] || (exp_r == '0);
    inf_z  = {sign_q, EXP_ONES, {FRC_W{1'b0}}};
    maxf_z = {sign_q, {(EXP_W-1){1'b1}}, 1'b0, {FRC_W{1'b1}}};
    case (rmode_q)
      RM_RTZ:  ovf_z = maxf_z;
      RM_RDN:  ovf_z = sign_q ? inf_z : maxf_z;
      RM_RUP:  ovf_z = sign_q ? maxf_z : inf_z;
      default: ovf_z = inf_z;
    endcase
    if (ovf)
      norm_z = ovf_z;
    else if (udf)
      norm_z = {sign_q, {(W-1){1'b0}}};
    else
      norm_z = {sign_q, exp_r[EXP_W-1:0], frac_r};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    ovrf_d  = ovrf_q;
    udrf_d  = udrf_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    exp_d   = exp_q;
    sign_d  = sign_q;
    rmode_d = rmode_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sign_d  = s_xy;
          rmode_d = r_mode;
          if (is_special) begin
            z_d     = special_z;
            ovrf_d  = 1'b0;
            udrf_d  = 1'b0;
            state_d = ST_DONE;
          end else begin
            acc_d   = '0;
            mcand_d = $signed({{(ACC_W-MW){1'b0}}, 1'b1, fx});
            mplr_d  = {{(MPL_W-MW-1){1'b0}}, 1'b1, fy, 1'b0};
            exp_d   = $signed({2'b00, ex}) + $signed({2'b00, ey}) - BIAS;
            cnt_d   = '0;
            state_d = ST_MUL;
          end
        end
      end
      ST_MUL: begin
        acc_d   = acc_q + pp;
        mcand_d = mcand_q <<< 2;
        mplr_d  = mplr_q >> 2;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_DIG)
          state_d = ST_NORM;
      end
      ST_NORM: begin
        z_d     = norm_z;
        ovrf_d  = ovf;
        udrf_d  = udf && !ovf;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      z_q     <= '0;
      ovrf_q  <= 1'b0;
      udrf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      ovrf_q  <= ovrf_d;
      udrf_q  <= udrf_d;
    end
  end

  // Datapath registers carry no reset; they are always loaded before use
  always_ff @(posedge clk) begin
    acc_q   <= acc_d;
    mcand_q <= mcand_d;
    mplr_q  <= mplr_d;
    exp_q   <= exp_d;
    sign_q  <= sign_d;
    rmode_q <= rmode_d;
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign fp_Z      = z_q;
  assign ovrf      = ovrf_q;
  assign udrf      = udrf_q;

endmodule

// File: tb/tb_fp_mul_seq.sv
// Self-checking bench for fp_mul_seq (FP32): directed corner cases, random
// operands against an arithmetic reference model, backpressure and reset abort.
module tb_fp_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] fp_X = '0;
  logic [31:0] fp_Y = '0;
  logic [2:0]  r_mode = '0;
  logic        in_ready;
  logic [31:0] fp_Z;
  logic        ovrf;
  logic        udrf;
  logic        out_valid;

  int checks = 0;
  int failures = 0;

  fp_mul_seq #(.EXP_W(8), .FRC_W(23)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fp_X      (fp_X),
    .fp_Y      (fp_Y),
    .r_mode    (r_mode),
    .fp_Z      (fp_Z),
    .ovrf      (ovrf),
    .udrf      (udrf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: exact integer product, remainder-vs-half rounding decision
  function automatic void ref_mul(input logic [31:0] x, input logic [31:0] y,
                                  input logic [2:0] rm, output logic [31:0] z,
                                  output logic ov, output logic ud);
    logic s;
    int ex, ey, e, sh;
    longint unsigned p, q, rem, half;
    bit up, xn, yn, xi, yi, xz, yz;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    xn = (ex == 255) && (x[22:0] != 0);
    yn = (ey == 255) && (y[22:0] != 0);
    xi = (ex == 255) && (x[22:0] == 0);
    yi = (ey == 255) && (y[22:0] == 0);
    xz = (ex == 0);
    yz = (ey == 0);
    ov = 1'b0;
    ud = 1'b0;
    if (xn || yn || (xi && yz) || (yi && xz)) z = 32'h7FC00000;
    else if (xi || yi) z = {s, 8'hFF, 23'd0};
    else if (xz || yz) z = {s, 31'd0};
    else begin
      p = 64'({1'b1, x[22:0]}) * 64'({1'b1, y[22:0]});
      e = ex + ey - 127;
      if (p >= 64'h8000_0000_0000) begin
        e++;
        sh = 24;
      end else begin
        sh = 23;
      end
      q    = p >> sh;
      rem  = p - (q << sh);
      half = 64'd1 << (sh - 1);
      case (rm)
        3'd1:    up = 1'b0;
        3'd2:    up = s && (rem != 0);
        3'd3:    up = !s && (rem != 0);
        3'd4:    up = (rem >= half);
        default: up = (rem > half) || ((rem == half) && q[0]);
      endcase
      q = q + 64'(up);
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        e++;
      end
      if (e >= 255) begin
        ov = 1'b1;
        case (rm)
          3'd1:    z = {s, 8'hFE, 23'h7FFFFF};
          3'd2:    z = s ? {s, 8'hFF, 23'd0} : {s, 8'hFE, 23'h7FFFFF};
          3'd3:    z = s ? {s, 8'hFE, 23'h7FFFFF} : {s, 8'hFF, 23'd0};
          default: z = {s, 8'hFF, 23'd0};
        endcase
      end else if (e <= 0) begin
        ud = 1'b1;
        z  = {s, 31'd0};
      end else begin
        z = {s, 8'(e), q[22:0]};
      end
    end
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0]  e;
    logic [22:0] f;
    case ($urandom_range(0, 9))
      0:       e = 8'd0;
      1:       e = 8'd255;
      2:       e = 8'($urandom_range(1, 20));
      3:       e = 8'($urandom_range(235, 254));
      default: e = 8'($urandom_range(100, 160));
    endcase
    f = 23'($urandom);
    if ($urandom_range(0, 7) == 0) f = '0;
    return {1'($urandom), e, f};
  endfunction

  task automatic start_op(input logic [31:0] x, input logic [31:0] y,
                          input logic [2:0] rm, output bit ok);
    int n;
    @(negedge clk);
    fp_X = x;
    fp_Y = y;
    r_mode = rm;
    in_valid = 1'b1;
    out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = in_ready;
    @(posedge clk);
  endtask

  // Scrambles operand inputs after accept to show they are sampled only once
  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      fp_X = $urandom;
      fp_Y = $urandom;
      r_mode = 3'($urandom);
      lat++;
    end while (!out_valid && lat < 60);
    if (!out_valid) lat = -1;
  endtask

  task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic [2:0] rm,
                       output logic [31:0] z, output logic ov, output logic ud, output int lat);
    bit ok;
    start_op(x, y, rm, ok);
    wait_result(lat);
    if (!ok) lat = -2;
    z  = fp_Z;
    ov = ovrf;
    ud = udrf;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({in_ready, out_valid, ovrf, udrf} !== 4'b1000 || fp_Z !== 32'h0) begin
      failures++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b ovrf=%b udrf=%b fp_Z=%h, want 1 0 0 0 00000000",
               in_ready, out_valid, ovrf, udrf, fp_Z);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [2:0]  rm;
    logic [31:0] z;
    logic        ov;
    logic        ud;
    int          lat;
  } vec_t;

  task automatic test_directed();
    vec_t v [17] = '{
      '{32'h3FC00000, 32'h40000000, 3'd0, 32'h40400000, 1'b0, 1'b0, 15},
      '{32'h3F800001, 32'h3F800001, 3'd0, 32'h3F800002, 1'b0, 1'b0, 15},
      '{32'h3F800001, 32'h3F800001, 3'd3, 32'h3F800003, 1'b0, 1'b0, 15},
      '{32'h3F800001, 32'h3F800001, 3'd1, 32'h3F800002, 1'b0, 1'b0, 15},
      '{32'h3F800001, 32'h3F800001, 3'd6, 32'h3F800002, 1'b0, 1'b0, 15},
      '{32'h7F000000, 32'h40000000, 3'd0, 32'h7F800000, 1'b1, 1'b0, 15},
      '{32'h7F000000, 32'h40000000, 3'd1, 32'h7F7FFFFF, 1'b1, 1'b0, 15},
      '{32'hFF000000, 32'h40000000, 3'd2, 32'hFF800000, 1'b1, 1'b0, 15},
      '{32'hFF000000, 32'h40000000, 3'd3, 32'hFF7FFFFF, 1'b1, 1'b0, 15},
      '{32'h00800000, 32'h00800000, 3'd0, 32'h00000000, 1'b0, 1'b1, 15},
      '{32'h3F800003, 32'h3FC00000, 3'd0, 32'h3FC00004, 1'b0, 1'b0, 15},
      '{32'h3F800003, 32'h3FC00000, 3'd4, 32'h3FC00005, 1'b0, 1'b0, 15},
      '{32'h3F800001, 32'h3FC00000, 3'd1, 32'h3FC00001, 1'b0, 1'b0, 15},
      '{32'h00000001, 32'hC0000000, 3'd0, 32'h80000000, 1'b0, 1'b0, 1},
      '{32'h7F800000, 32'h00000000, 3'd0, 32'h7FC00000, 1'b0, 1'b0, 1},
      '{32'h7F800000, 32'hC0000000, 3'd1, 32'hFF800000, 1'b0, 1'b0, 1},
      '{32'hFFC00001, 32'h3F800000, 3'd0, 32'h7FC00000, 1'b0, 1'b0, 1}
    };
    logic [31:0] z;
    logic ov, ud;
    int lat;
    for (int i = 0; i < 17; i++) begin
      do_op(v[i].x, v[i].y, v[i].rm, z, ov, ud, lat);
      checks++;
      if (z !== v[i].z) begin
        failures++;
        $display("FAIL directed[%0d] fp_Z: got %h want %h", i, z, v[i].z);
      end
      checks++;
      if ({ov, ud} !== {v[i].ov, v[i].ud}) begin
        failures++;
        $display("FAIL directed[%0d] flags ovrf/udrf: got %b%b want %b%b", i, ov, ud, v[i].ov, v[i].ud);
      end
      checks++;
      if (lat !== v[i].lat) begin
        failures++;
        $display("FAIL directed[%0d] latency: got %0d want %0d", i, lat, v[i].lat);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] x, y, z, ez;
    logic [2:0] rm;
    logic ov, ud, eov, eud;
    int lat, elat;
    for (int i = 0; i < 60; i++) begin
      x  = rand_fp();
      y  = rand_fp();
      rm = 3'($urandom);
      ref_mul(x, y, rm, ez, eov, eud);
      elat = (x[30:23] == 8'd0 || x[30:23] == 8'hFF || y[30:23] == 8'd0 || y[30:23] == 8'hFF) ? 1 : 15;
      do_op(x, y, rm, z, ov, ud, lat);
      checks++;
      if (z !== ez || {ov, ud} !== {eov, eud}) begin
        failures++;
        $display("FAIL random[%0d] %h*%h rm=%0d: got %h ov=%b ud=%b want %h ov=%b ud=%b",
                 i, x, y, rm, z, ov, ud, ez, eov, eud);
      end
      checks++;
      if (lat !== elat) begin
        failures++;
        $display("FAIL random[%0d] latency: got %0d want %0d", i, lat, elat);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int lat;
    start_op(32'h3F800001, 32'h3F800001, 3'd3, ok);
    wait_result(lat);
    checks++;
    if (!ok || lat !== 15) begin
      failures++;
      $display("FAIL backpressure latency: got %0d want 15", lat);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      fp_X = $urandom;
      fp_Y = $urandom;
      @(negedge clk);
      checks++;
      if (fp_Z !== 32'h3F800003 || {ovrf, udrf} !== 2'b00 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL backpressure hold[%0d]: fp_Z=%h flags=%b%b in_ready=%b out_valid=%b, want 3f800003 00 0 1",
                 i, fp_Z, ovrf, udrf, in_ready, out_valid);
      end
    end
    // in_valid stays high across the handshake edge: it must not be taken there
    fp_X = 32'h3FC00000;
    fp_Y = 32'h40000000;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL handshake_to_idle: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL no_phantom_accept: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_midop();
    bit ok;
    int seen;
    logic [31:0] z;
    logic ov, ud;
    int lat;
    start_op(32'h7F000000, 32'h40000000, 3'd0, ok);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || fp_Z !== 32'h0 || {ovrf, udrf} !== 2'b00) begin
      failures++;
      $display("FAIL reset_midop async: out_valid=%b in_ready=%b fp_Z=%h flags=%b%b, want 0 1 00000000 00",
               out_valid, in_ready, fp_Z, ovrf, udrf);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL reset_midop discard: out_valid seen %0d cycles, want 0", seen);
    end
    do_op(32'h3FC00000, 32'h40000000, 3'd0, z, ov, ud, lat);
    checks++;
    if (z !== 32'h40400000 || {ov, ud} !== 2'b00 || lat !== 15) begin
      failures++;
      $display("FAIL reset_midop next_op: fp_Z=%h flags=%b%b lat=%0d, want 40400000 00 15", z, ov, ud, lat);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_mul_seq.md
FP_MUL_SEQ -- requirements
Module: fp_mul_seq

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter FRC_W, default 23, stored fraction width; word width W = 1+EXP_W+FRC_W.
REQ-003 SHALL have ports: clk  input  1  clock, single domain; rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports: in_valid  input  1  operand strobe; in_ready  output  1  block can accept.
REQ-005 SHALL have ports: fp_X, fp_Y  input  W  operands; r_mode  input  3  rounding mode, sampled with operands.
REQ-006 SHALL have ports: fp_Z  output  W  product; ovrf, udrf  output  1  overflow and underflow flags.
REQ-007 SHALL have ports: out_valid  output  1  result strobe; out_ready  input  1  consumer accepts.

Function
REQ-008 SHALL accept operands on the clk edge where in_valid && in_ready; in_ready SHALL be 1 only in IDLE.
REQ-009 SHALL use FSM states IDLE, MUL, NORM, DONE: IDLE->MUL on a normal-operand accept; IDLE->DONE on a special-case accept; MUL->NORM after the last digit; NORM->DONE; DONE->IDLE when out_ready.
REQ-010 SHALL classify a field as subnormal when exp==0 and as Inf/NaN when exp is all-ones; a subnormal operand SHALL be treated as zero (flush-to-zero).
REQ-011 SHALL apply special cases (result in DONE 1 cycle after accept), in priority order:
- any NaN, or Inf*zero/subnormal -> canonical qNaN (exp all-ones, frac MSB 1, sign 0);
- Inf * other -> Inf, sign = sign X xor sign Y;
- zero/subnormal * finite -> signed zero {sX^sY, 0}.
- Flags SHALL be 0 for all special cases.
REQ-012 SHALL multiply the significands {1,frc} by radix-4 Booth recoding, one digit per cycle in MUL. NDIG = (FRC_W+3)/2 digits, with the multiplier zero-extended so the unsigned product is exact (13 digits for FP32).
REQ-013 SHALL hold the partial-product accumulator at 2*(FRC_W+1)+2 bits signed; the final accumulator SHALL equal the exact unsigned product of the significands.
REQ-014 SHALL compute the biased exponent as eX+eY-bias (bias = 2^(EXP_W-1)-1) in EXP_W+2 signed bits, +1 when product bit 2*FRC_W+1 is set (normalize right by one).
REQ-015 SHALL round in NORM using guard, round and sticky bits per r_mode:
- 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM;
- 101-111 SHALL behave as RNE;
- a mantissa carry-out SHALL increment the exponent.
REQ-016 SHALL handle overflow (final exponent >= all-ones) with ovrf=1, and the result by mode:
- RNE/RMM -> Inf;
- RTZ -> max finite;
- RDN -> +max finite / -Inf;
- RUP -> +Inf / -max finite.
REQ-017 SHALL handle underflow (final exponent <= 0) by producing signed zero with udrf=1 (no subnormal output).
REQ-018 SHALL report normal-path latency from accept to out_valid of NDIG+2 cycles (15 for FP32).
REQ-019 SHALL assert out_valid only in DONE; fp_Z, ovrf and udrf SHALL be stable while out_valid && !out_ready.
REQ-020 SHALL ignore in_valid when not in IDLE; a transfer where out_valid && out_ready SHALL return the block to IDLE on the next cycle (no same-cycle re-accept).

Reset
REQ-021 SHALL, while rst_n is low, force the state to IDLE, in_ready=1, out_valid=0, fp_Z=0, ovrf=0 and udrf=0, regardless of clk.
REQ-022 SHALL discard any in-flight operation on a reset asserted in any state; no result for it SHALL ever appear.

Structure
REQ-023 SHALL take the r_mode encoding enum, the FSM state enum, and the bias/NDIG helper functions from shared package fp_pkg.
REQ-024 SHALL place the Booth digit recoder (3 multiplier bits in -> {zero, x2, neg}) in sub-module booth_r4_enc, instantiated once.

Verification
REQ-025 SHALL cover: 0x3FC00000 * 0x40000000, RNE -> fp_Z=0x40400000, flags 0, out_valid exactly 15 cycles after accept.
REQ-026 SHALL cover: 0x3F800001 * 0x3F800001 -> RNE 0x3F800002; RUP 0x3F800003; RTZ 0x3F800002.
REQ-027 SHALL cover: 0x7F000000 * 0x40000000 -> RNE 0x7F800000 with ovrf=1; RTZ 0x7F7FFFFF with ovrf=1. 0x00800000 * 0x00800000 -> 0x00000000 with udrf=1.
REQ-028 SHALL cover: 0x00000001 * 0xC0000000 -> 0x80000000; 0x7F800000 * 0x00000000 -> 0x7FC00000; both with out_valid 1 cycle after accept and flags 0.
REQ-029 SHALL cover: out_ready held low 5 cycles in DONE -> fp_Z and flags stable, in_ready=0 and in_valid ignored throughout.
REQ-030 SHALL cover: rst_n pulsed low during the 5th MUL cycle -> out_valid=0 and in_ready=1 immediately; the next operation completes correctly.
